// File: rtl/cim_xbar_tile_if.sv
// Crossbar-tile bus: input/weight write streams, start/busy/done handshake and result read port.
interface cim_xbar_tile_if #(
  parameter int unsigned xbar_size     = 512,
  parameter int unsigned datatype_size = 8
);
  localparam int unsigned AddrW = (xbar_size > 1) ? $clog2(xbar_size) : 1;

  logic                     i_we;
  logic [AddrW-1:0]         i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_wgt_we;
  logic [AddrW-1:0]         i_wgt_row;
  logic [xbar_size-1:0]     i_wgt_data;
  logic                     i_start;
  logic                     o_busy;
  logic                     o_done;
  logic [AddrW-1:0]         i_rd_addr;
  logic [datatype_size-1:0] o_rd_data;

  modport master (
    output i_we, i_wr_addr, i_wr_data, i_wgt_we, i_wgt_row, i_wgt_data, i_start, i_rd_addr,
    input  o_busy, o_done, o_rd_data
  );

  modport slave (
    input  i_we, i_wr_addr, i_wr_data, i_wgt_we, i_wgt_row, i_wgt_data, i_start, i_rd_addr,
    output o_busy, o_done, o_rd_data
  );
endinterface

// File: rtl/cim_xbar_tile.sv
// Crossbar tile responder: row-serial binary-weight MVM over an input register file.
// Define CIM_XBAR_TILE_SIGNED_EN for two's-complement inputs, accumulation and saturation.
module cim_xbar_tile #(
  parameter int unsigned xbar_size     = 512,
  parameter int unsigned datatype_size = 8,
  parameter int unsigned active_rows   = xbar_size,
  parameter int unsigned out_shift     = 0,
  parameter int unsigned acc_width     = datatype_size + $clog2(xbar_size) + 1
) (
  input logic            clk,
  input logic            rst,
  cim_xbar_tile_if.slave bus
);
  localparam int unsigned AddrW = (xbar_size > 1) ? $clog2(xbar_size) : 1;
  localparam int unsigned ExtW  = acc_width - datatype_size;

`ifdef CIM_XBAR_TILE_SIGNED_EN
  localparam logic [acc_width-1:0] SatMax = {{(ExtW + 1){1'b0}}, {(datatype_size - 1){1'b1}}};
  localparam logic [acc_width-1:0] SatMin = {{(ExtW + 1){1'b1}}, {(datatype_size - 1){1'b0}}};
`else
  localparam logic [acc_width-1:0] SatMax = {{ExtW{1'b0}}, {datatype_size{1'b1}}};
`endif

  typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

  state_e r_state, w_state_next;

  logic [datatype_size-1:0] r_in_buf  [xbar_size];
  logic [xbar_size-1:0]     r_wgt     [xbar_size];
  logic [acc_width-1:0]     r_acc     [xbar_size];
  logic [datatype_size-1:0] r_out_buf [xbar_size];
  logic [AddrW-1:0]         r_row;
  logic                     r_done;
  logic [datatype_size-1:0] r_rd_data;

  logic                     w_idle, w_clear, w_accum, w_commit, w_last_row;
  logic                     w_wr_ok, w_wgt_ok, w_rd_ok;
  logic [acc_width-1:0]     w_addend;
  logic [acc_width-1:0]     w_shift [xbar_size];
  logic [datatype_size-1:0] w_sat   [xbar_size];

  assign w_idle     = (r_state == StIdle);
  assign w_last_row = (r_row == AddrW'(active_rows - 1));
  // Out-of-range addresses only exist for non-power-of-two sizes.
  assign w_wr_ok    = (32'(bus.i_wr_addr) < xbar_size);
  assign w_wgt_ok   = (32'(bus.i_wgt_row) < xbar_size);
  assign w_rd_ok    = (32'(bus.i_rd_addr) < xbar_size);

`ifdef CIM_XBAR_TILE_SIGNED_EN
  assign w_addend = {{ExtW{r_in_buf[r_row][datatype_size-1]}}, r_in_buf[r_row]};
`else
  assign w_addend = {{ExtW{1'b0}}, r_in_buf[r_row]};
`endif

  always_comb begin
    for (int c = 0; c < xbar_size; c++) begin
      w_shift[c] = '0;
      w_sat[c]   = '0;
`ifdef CIM_XBAR_TILE_SIGNED_EN
      w_shift[c] = $signed(r_acc[c]) >>> out_shift;
      if ($signed(w_shift[c]) > $signed(SatMax)) begin
        w_sat[c] = SatMax[datatype_size-1:0];
      end else if ($signed(w_shift[c]) < $signed(SatMin)) begin
        w_sat[c] = SatMin[datatype_size-1:0];
      end else begin
        w_sat[c] = w_shift[c][datatype_size-1:0];
      end
`else
      w_shift[c] = r_acc[c] >> out_shift;
      w_sat[c]   = (w_shift[c] > SatMax) ? SatMax[datatype_size-1:0]
                                         : w_shift[c][datatype_size-1:0];
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accum      = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_start) begin
          w_state_next = StCompute;
          w_clear      = 1'b1;
        end
      end
      StCompute: begin
        w_accum = 1'b1;
        if (w_last_row) w_state_next = StCommit;
      end
      StCommit: begin
        w_commit     = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < xbar_size; i++) begin
        r_in_buf[i]  <= '0;
        r_wgt[i]     <= '0;
        r_acc[i]     <= '0;
        r_out_buf[i] <= '0;
      end
      r_row     <= '0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done    <= w_commit;
      r_rd_data <= w_rd_ok ? r_out_buf[bus.i_rd_addr] : '0;
      if (w_idle && bus.i_we && w_wr_ok)      r_in_buf[bus.i_wr_addr] <= bus.i_wr_data;
      if (w_idle && bus.i_wgt_we && w_wgt_ok) r_wgt[bus.i_wgt_row]    <= bus.i_wgt_data;
      if (w_clear) begin
        r_row <= '0;
        for (int c = 0; c < xbar_size; c++) r_acc[c] <= '0;
      end
      if (w_accum) begin
        r_row <= r_row + 1'b1;
        for (int c = 0; c < xbar_size; c++) begin
          if (r_wgt[r_row][c]) r_acc[c] <= r_acc[c] + w_addend;
        end
      end
      if (w_commit) begin
        for (int c = 0; c < xbar_size; c++) r_out_buf[c] <= w_sat[c];
      end
    end
  end

  // Busy spans the start edge through the commit edge, so it follows the state directly.
  assign bus.o_busy    = ~w_idle;
  assign bus.o_done    = r_done;
  assign bus.o_rd_data = r_rd_data;
endmodule

// File: tb/tb_cim_xbar_tile.sv
// Self-checking bench for cim_xbar_tile: two tiles (out_shift 0 and 3) against a sum-of-products model.
module tb_cim_xbar_tile;
  localparam int unsigned XS = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AR = 8;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_xbar_tile_if #(.xbar_size(XS), .datatype_size(DW)) bus0 ();
  cim_xbar_tile_if #(.xbar_size(XS), .datatype_size(DW)) bus3 ();

  assign bus3.i_we       = bus0.i_we;
  assign bus3.i_wr_addr  = bus0.i_wr_addr;
  assign bus3.i_wr_data  = bus0.i_wr_data;
  assign bus3.i_wgt_we   = bus0.i_wgt_we;
  assign bus3.i_wgt_row  = bus0.i_wgt_row;
  assign bus3.i_wgt_data = bus0.i_wgt_data;
  assign bus3.i_start    = bus0.i_start;
  assign bus3.i_rd_addr  = bus0.i_rd_addr;

  cim_xbar_tile #(.xbar_size(XS), .datatype_size(DW), .active_rows(AR), .out_shift(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  cim_xbar_tile #(.xbar_size(XS), .datatype_size(DW), .active_rows(AR), .out_shift(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;
  int in_m [XS];
  bit w_m  [XS][XS];
  int exp0 [XS];
  int exp3 [XS];

  function automatic int as_elem(int v);
`ifdef CIM_XBAR_TILE_SIGNED_EN
    return ((v & 255) >= 128) ? (v & 255) - 256 : (v & 255);
`else
    return v & 255;
`endif
  endfunction

  function automatic int clampv(int s);
`ifdef CIM_XBAR_TILE_SIGNED_EN
    return (s > 127) ? 127 : ((s < -128) ? -128 : s);
`else
    return (s > 255) ? 255 : s;
`endif
  endfunction

  task automatic model_compute();
    for (int c = 0; c < XS; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < AR; r++) if (w_m[r][c]) s += as_elem(in_m[r]);
      exp0[c] = clampv(s);
      exp3[c] = clampv(s >>> 3);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < XS; i++) begin
      in_m[i] = 0;
      exp0[i] = 0;
      exp3[i] = 0;
      for (int j = 0; j < XS; j++) w_m[i][j] = 1'b0;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wr_in(int a, int v, bit upd);
    @(negedge clk);
    bus0.i_we      = 1'b1;
    bus0.i_wr_addr = AW'(a);
    bus0.i_wr_data = DW'(v);
    @(posedge clk);
    #1 bus0.i_we = 1'b0;
    if (upd) in_m[a] = v & 255;
  endtask

  task automatic wr_wgt(int row, logic [XS-1:0] bits, bit upd);
    @(negedge clk);
    bus0.i_wgt_we   = 1'b1;
    bus0.i_wgt_row  = AW'(row);
    bus0.i_wgt_data = bits;
    @(posedge clk);
    #1 bus0.i_wgt_we = 1'b0;
    if (upd) for (int c = 0; c < XS; c++) w_m[row][c] = bits[c];
  endtask

  task automatic rd_check(int a, string tag);
    @(negedge clk);
    bus0.i_rd_addr = AW'(a);
    @(negedge clk);
    check({tag, "_s0"}, 32'(bus0.o_rd_data), 32'(exp0[a] & 255));
    check({tag, "_s3"}, 32'(bus3.o_rd_data), 32'(exp3[a] & 255));
  endtask

  task automatic rd_all(string tag);
    for (int c = 0; c < XS; c++) rd_check(c, tag);
  endtask

  // Start a computation and watch busy/done; optionally write alongside start or meddle mid-run.
  task automatic run(bit interfere, bit co_wr, int a, int v);
    int busy_cnt, done_at, done_cnt;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk);
    bus0.i_start = 1'b1;
    if (co_wr) begin
      bus0.i_we      = 1'b1;
      bus0.i_wr_addr = AW'(a);
      bus0.i_wr_data = DW'(v);
      in_m[a]        = v & 255;
    end
    @(posedge clk);
    #1;
    bus0.i_start = 1'b0;
    bus0.i_we    = 1'b0;
    for (int j = 0; j < int'(AR) + 12; j++) begin
      @(negedge clk);
      if (bus0.o_busy === 1'b1) busy_cnt++;
      if (bus0.o_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (interfere && j == 3) begin
        check("rd_during_compute_s0", 32'(bus0.o_rd_data), 32'(exp0[3] & 255));
        check("rd_during_compute_s3", 32'(bus3.o_rd_data), 32'(exp3[3] & 255));
      end
      if (interfere && j == 2) begin
        bus0.i_start    = 1'b1;
        bus0.i_we       = 1'b1;
        bus0.i_wr_addr  = '0;
        bus0.i_wr_data  = DW'(99);
        bus0.i_wgt_we   = 1'b1;
        bus0.i_wgt_row  = '0;
        bus0.i_wgt_data = '0;
        bus0.i_rd_addr  = AW'(3);
        @(posedge clk);
        #1;
        bus0.i_start  = 1'b0;
        bus0.i_we     = 1'b0;
        bus0.i_wgt_we = 1'b0;
      end
    end
    model_compute();
    check("busy_cycles", busy_cnt, AR + 1);
    check("done_cycle", done_at, AR + 1);
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin
    bus0.i_we       = 1'b0;
    bus0.i_wr_addr  = '0;
    bus0.i_wr_data  = '0;
    bus0.i_wgt_we   = 1'b0;
    bus0.i_wgt_row  = '0;
    bus0.i_wgt_data = '0;
    bus0.i_start    = 1'b0;
    bus0.i_rd_addr  = '0;
    rst             = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus0.o_busy), 0);
    check("rst_done", 32'(bus0.o_done), 0);
    check("rst_rd_s0", 32'(bus0.o_rd_data), 0);
    check("rst_rd_s3", 32'(bus3.o_rd_data), 0);
    @(negedge clk);
    rst = 1'b1;

    // Inputs 1..8, all weights set: every column sums to 36.
    for (int r = 0; r < AR; r++) begin
      wr_in(r, r + 1, 1'b1);
      wr_wgt(r, 8'hFF, 1'b1);
    end
    run(1'b0, 1'b0, 0, 0);
    rd_all("all_ones");

    // Diagonal weights pick out one input per column.
    for (int r = 0; r < AR; r++) begin
      wr_in(r, 10 * (r + 1), 1'b1);
      wr_wgt(r, 8'(1 << r), 1'b1);
    end
    run(1'b0, 1'b0, 0, 0);
    rd_all("diag");

    // Start/write/program while busy must all be dropped.
    for (int r = 0; r < AR; r++) begin
      wr_in(r, r + 1, 1'b1);
      wr_wgt(r, 8'hFF, 1'b1);
    end
    run(1'b1, 1'b0, 0, 0);
    rd_all("busy_drop");

    for (int r = 0; r < AR; r++) wr_in(r, 255, 1'b1);
    run(1'b0, 1'b0, 0, 0);
    rd_all("saturate");

    // Reset while row 4 is being summed.
    @(negedge clk);
    bus0.i_start = 1'b1;
    @(posedge clk);
    #1 bus0.i_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus0.o_busy), 0);
    check("midrst_done", 32'(bus0.o_done), 0);
    check("midrst_rd_s0", 32'(bus0.o_rd_data), 0);
    check("midrst_rd_s3", 32'(bus3.o_rd_data), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd_check(5, "post_rst");
    rd_check(2, "post_rst");
    for (int r = 0; r < AR; r++) begin
      wr_in(r, r + 1, 1'b1);
      wr_wgt(r, 8'hFF, 1'b1);
    end
    run(1'b0, 1'b0, 0, 0);
    rd_all("post_rst_run");

`ifdef CIM_XBAR_TILE_SIGNED_EN
    for (int r = 0; r < AR; r++) wr_in(r, -100, 1'b1);
    run(1'b0, 1'b0, 0, 0);
    rd_all("signed_neg");
`endif

    // Random rounds; the start cycle also carries a write that must be used.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < AR; r++) begin
        wr_in(r, int'($urandom_range(0, 255)), 1'b1);
        wr_wgt(r, 8'($urandom), 1'b1);
      end
      run(1'b0, 1'b1, int'($urandom_range(0, AR - 1)), int'($urandom_range(0, 255)));
      for (int i = 0; i < XS; i++) rd_check(int'($urandom_range(0, XS - 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cim_xbar_tile.md
Name: cim_xbar_tile

Overview:
Behavioural crossbar-tile responder for one (v,h) tile position of an fc_layer.
- Receives the layer's crossbar write stream (row address plus input element) into an input register file.
- On start, computes a row-serial binary-weight MVM across all columns and asserts busy while computing.
- Serves column results back on the read interface with 1-cycle read latency.
- Instantiated v_cim_tiles × h_cim_tiles times beside each fc_layer in simulation and performance models.

Parameters:
- xbar_size, 512: crossbar rows and columns; also input-buffer and output-buffer depth.
- datatype_size, 8: input element width and output element width.
- active_rows, xbar_size: rows summed per computation (1..xbar_size).
- out_shift, 0: right shift applied to each accumulator before saturation.
- acc_width, datatype_size+$clog2(xbar_size)+1: per-column accumulator width.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset.
- i_we, input, 1: input-row write strobe.
- i_wr_addr, input, $clog2(xbar_size): input row address.
- i_wr_data, input, datatype_size: input element (unsigned).
- i_wgt_we, input, 1: weight-row program strobe.
- i_wgt_row, input, $clog2(xbar_size): weight row address.
- i_wgt_data, input, xbar_size: 1-bit cells of that row; bit c is column c.
- i_start, input, 1: start-computation pulse.
- o_busy, output, 1: high during computation.
- o_done, output, 1: one-cycle pulse when results are committed.
- i_rd_addr, input, $clog2(xbar_size): result column address.
- o_rd_data, output, datatype_size: result for the column at i_rd_addr.

Behaviour:
- Reset (rst low, asynchronous), which also applies mid-computation:
  - State goes to IDLE.
  - o_busy, o_done, o_rd_data reset to 0.
  - Input buffer, weight array, accumulators, output buffer and row counter all clear to 0.
  - Any computation in progress is abandoned; there is no partial commit.
- States: IDLE, COMPUTE, COMMIT.
- IDLE:
  - i_start=1 → COMPUTE next cycle; row counter=0, all accumulators=0, o_busy=1 registered the same edge.
  - Otherwise stay in IDLE.
- COMPUTE, one row per cycle:
  - For each column c: acc[c] += in_buf[row] if w[row][c]=1, else unchanged.
  - row increments. After row active_rows-1 is summed → COMMIT.
- COMMIT, one cycle:
  - For each column c: out_buf[c] = min(acc[c] >> out_shift, 2^datatype_size-1).
  - o_done pulses on this edge, o_busy drops, next state IDLE.
- Latency: i_start high at edge N gives o_done high in cycle N+active_rows+1. Total busy time is active_rows+1 cycles.
- Write and start rules:
  - i_start is ignored while o_busy=1; no queuing.
  - i_we and i_wgt_we are honoured only in IDLE; writes while busy are dropped and the buffers stay unchanged.
  - i_we and i_start in the same IDLE cycle: the write lands first, and the computation uses the new value.
  - i_we and i_wgt_we in the same cycle: both are performed.
- Read port:
  - Always active: o_rd_data <= out_buf[i_rd_addr] every cycle, giving 1-cycle latency.
  - During COMPUTE it returns the previous committed results.
  - A read in the COMMIT cycle returns the old value; new values are visible from the following cycle.
- Addresses ≥ xbar_size (non-power-of-two sizes only): writes are dropped and reads return 0.
- Arithmetic: no overflow is possible, since acc_width covers active_rows·(2^datatype_size−1).

Optional Feature:
- Macro: CIM_XBAR_TILE_SIGNED_EN.
- When defined:
  - i_wr_data and o_rd_data are two's complement.
  - Accumulation is signed with sign-extension.
  - The shift is arithmetic.
  - Saturation clamps to [−2^(datatype_size−1), 2^(datatype_size−1)−1].
- When undefined: unsigned arithmetic and saturation as described above.

Test Plan:
1. Set xbar_size=8, active_rows=8. Load in=1..8 and all weights 1, pulse start → o_busy high 9 cycles, o_done at start+9, every column reads 36.
2. Use diagonal weights (w[r][r]=1) with in=10,20,…,80 → column c reads 10·(c+1); reading column 3 returns 40 one cycle after the address is applied.
3. Load all inputs 255 with all weights 1 and out_shift=0 → every column saturates to 255. Repeat with out_shift=3 → 255.
4. During COMPUTE, pulse i_start, write in[0]=99 and program weight row 0 → none take effect. Results equal the scenario-1 values, and reads during COMPUTE return the prior results.
5. Assert rst low mid-COMPUTE at row 4 → o_busy=0 immediately and all reads return 0. A new load and start afterwards produces correct results.
6. Define CIM_XBAR_TILE_SIGNED_EN and set all inputs to −100 with all weights 1 → every column reads −128 (0x80).
